// File: rtl/llc_pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// llc_pipe_ctrl_pkg
// Shared constants and types for the LLC pipeline controller.
//   LLC_PIPE_STAGES  : default pipeline depth
//   LLC_SET_BITS     : default set-index width
//   LLC_PKT_WIDTH    : default opaque payload width
//   llc_set_t        : set index type
//   llc_pipe_entry_t : {set, pkt} record held by one pipeline stage
//   sat_inc32()      : saturating 32-bit increment used by the statistics
// ---------------------------------------------------------------------------
package llc_pipe_ctrl_pkg;

   localparam int LLC_PIPE_STAGES = 5;
   localparam int LLC_SET_BITS    = 9;
   localparam int LLC_PKT_WIDTH   = 16;

   typedef logic [LLC_SET_BITS-1:0] llc_set_t;

   typedef struct packed {
      llc_set_t                 set;
      logic [LLC_PKT_WIDTH-1:0] pkt;
   } llc_pipe_entry_t;

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/llc_pipe_stage.sv
// ---------------------------------------------------------------------------
// llc_pipe_stage
// One pipeline slot: a valid bit plus the set index and payload of the
// request it holds.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset (clears valid and data)
//   flush_i  : synchronous clear of the valid bit (has priority)
//   load_i   : capture set_i/pkt_i and mark the slot valid
//   clear_i  : occupant has moved on; mark the slot empty
//   set_i    : incoming set index
//   pkt_i    : incoming payload
//   valid_o  : slot occupied
//   set_o    : held set index
//   pkt_o    : held payload
// load_i wins over clear_i so a slot that empties and refills in the same
// cycle stays valid with the new occupant.
// ---------------------------------------------------------------------------
module llc_pipe_stage
   import llc_pipe_ctrl_pkg::*;
#(
   parameter int SET_BITS  = LLC_SET_BITS,
   parameter int PKT_WIDTH = LLC_PKT_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic                 load_i,
   input  logic                 clear_i,
   input  logic [SET_BITS-1:0]  set_i,
   input  logic [PKT_WIDTH-1:0] pkt_i,
   output logic                 valid_o,
   output logic [SET_BITS-1:0]  set_o,
   output logic [PKT_WIDTH-1:0] pkt_o
);

   logic                 valid_q, valid_d;
   logic [SET_BITS-1:0]  set_q, set_d;
   logic [PKT_WIDTH-1:0] pkt_q, pkt_d;

   always_comb begin
      valid_d = valid_q;
      set_d   = set_q;
      pkt_d   = pkt_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         set_d   = set_i;
         pkt_d   = pkt_i;
      end else if (clear_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         set_q   <= '0;
         pkt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         set_q   <= set_d;
         pkt_q   <= pkt_d;
      end
   end

   assign valid_o = valid_q;
   assign set_o   = set_q;
   assign pkt_o   = pkt_q;

endmodule

// File: rtl/llc_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// llc_pipe_ctrl
// In-order pipeline controller for the LLC core: NUM_STAGES overlapped
// stages with per-stage done/backpressure and a set-hazard check at entry.
//   clk_i         : clock
//   rst_ni        : asynchronous active-low reset
//   flush_i       : synchronous clear of all stages
//   in_valid_i    : new request offered
//   in_ready_o    : request accepted on this edge when in_valid_i & in_ready_o
//   in_set_i      : set of the offered request
//   in_pkt_i      : payload of the offered request
//   stage_done_i  : bit i set -> stage i finished and may advance
//   stage_valid_o : occupancy per stage
//   stage_set_o   : flattened, stage i at [i*SET_BITS +: SET_BITS]
//   stage_pkt_o   : flattened, stage i at [i*PKT_WIDTH +: PKT_WIDTH]
//   hazard_o      : in_valid_i and in_set_i matches a valid stage's set
//   out_valid_o   : last stage valid and done
//   out_ready_i   : downstream accepts
//   out_set_o     : set of the last stage
//   out_pkt_o     : payload of the last stage
// Optional build macro LLC_PIPE_STATS_EN adds saturating counters:
//   stat_hazard_cnt_o : cycles with in_valid_i & hazard_o
//   stat_stall_cnt_o  : cycles with in_valid_i & !in_ready_o & !hazard_o
// ---------------------------------------------------------------------------
module llc_pipe_ctrl
   import llc_pipe_ctrl_pkg::*;
#(
   parameter int NUM_STAGES = LLC_PIPE_STAGES,
   parameter int SET_BITS   = LLC_SET_BITS,
   parameter int PKT_WIDTH  = LLC_PKT_WIDTH
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            flush_i,
   input  logic                            in_valid_i,
   output logic                            in_ready_o,
   input  logic [SET_BITS-1:0]             in_set_i,
   input  logic [PKT_WIDTH-1:0]            in_pkt_i,
   input  logic [NUM_STAGES-1:0]           stage_done_i,
   output logic [NUM_STAGES-1:0]           stage_valid_o,
   output logic [NUM_STAGES*SET_BITS-1:0]  stage_set_o,
   output logic [NUM_STAGES*PKT_WIDTH-1:0] stage_pkt_o,
   output logic                            hazard_o,
   output logic                            out_valid_o,
   input  logic                            out_ready_i,
   output logic [SET_BITS-1:0]             out_set_o,
   output logic [PKT_WIDTH-1:0]            out_pkt_o
`ifdef LLC_PIPE_STATS_EN
   ,
   output logic [31:0]                     stat_hazard_cnt_o,
   output logic [31:0]                     stat_stall_cnt_o
`endif
);

   logic [NUM_STAGES-1:0] valid;
   logic [NUM_STAGES-1:0] adv;
   logic [NUM_STAGES-1:0] load;
   logic [NUM_STAGES-1:0] match;
   logic [SET_BITS-1:0]   set_arr [NUM_STAGES];
   logic [PKT_WIDTH-1:0]  pkt_arr [NUM_STAGES];
   logic                  accept;

   for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
         assign load[gi] = accept;
      end else begin : g_body
         assign load[gi] = adv[gi-1];
      end

      llc_pipe_stage #(
         .SET_BITS  (SET_BITS),
         .PKT_WIDTH (PKT_WIDTH)
      ) u_stage (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .flush_i (flush_i),
         .load_i  (load[gi]),
         .clear_i (adv[gi]),
         .set_i   ((gi == 0) ? in_set_i : set_arr[(gi == 0) ? 0 : gi-1]),
         .pkt_i   ((gi == 0) ? in_pkt_i : pkt_arr[(gi == 0) ? 0 : gi-1]),
         .valid_o (valid[gi]),
         .set_o   (set_arr[gi]),
         .pkt_o   (pkt_arr[gi])
      );

      // Compare against every stage valid at the start of the cycle, even a
      // retiring one: a same-set follower always waits one extra cycle, which
      // keeps the bubble count independent of downstream timing.
      assign match[gi] = valid[gi] & (set_arr[gi] == in_set_i);

      assign stage_set_o[gi*SET_BITS  +: SET_BITS]  = set_arr[gi];
      assign stage_pkt_o[gi*PKT_WIDTH +: PKT_WIDTH] = pkt_arr[gi];
   end

   assign out_valid_o = valid[NUM_STAGES-1] & stage_done_i[NUM_STAGES-1] & ~flush_i;

   // Ready chain evaluated from the tail backwards so a full pipe can move
   // every stage on the same edge.
   always_comb begin
      adv             = '0;
      adv[NUM_STAGES-1] = out_valid_o & out_ready_i;
      for (int i = NUM_STAGES-2; i >= 0; i--) begin
         adv[i] = valid[i] & stage_done_i[i] & (~valid[i+1] | adv[i+1]);
      end
   end

   assign hazard_o   = in_valid_i & (|match);
   // rst_ni gating keeps in_ready low while reset is held, not just after it.
   assign in_ready_o = rst_ni & (~valid[0] | adv[0]) & ~hazard_o & ~flush_i;
   assign accept     = in_valid_i & in_ready_o;

   assign stage_valid_o = valid;
   assign out_set_o     = set_arr[NUM_STAGES-1];
   assign out_pkt_o     = pkt_arr[NUM_STAGES-1];

`ifdef LLC_PIPE_STATS_EN
   logic [31:0] hazard_cnt_q, hazard_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      hazard_cnt_d = hazard_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      if (hazard_o) begin
         hazard_cnt_d = sat_inc32(hazard_cnt_q);
      end
      if (in_valid_i & ~in_ready_o & ~hazard_o) begin
         stall_cnt_d = sat_inc32(stall_cnt_q);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hazard_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         hazard_cnt_q <= hazard_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign stat_hazard_cnt_o = hazard_cnt_q;
   assign stat_stall_cnt_o  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_llc_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_llc_pipe_ctrl
// Bench for llc_pipe_ctrl (NUM_STAGES=5, SET_BITS=9, PKT_WIDTH=16): vector
// table, directed multi-cycle sequences, then random traffic against a
// slot-sweep reference model.  Build with LLC_PIPE_STATS_EN to also check
// the statistics counters.
// ---------------------------------------------------------------------------
module tb_llc_pipe_ctrl;

   localparam int N  = 5;
   localparam int SB = 9;
   localparam int PW = 16;

   logic            clk;
   logic            rst_n;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [SB-1:0]   in_set;
   logic [PW-1:0]   in_pkt;
   logic [N-1:0]    done;
   logic [N-1:0]    stage_valid;
   logic [N*SB-1:0] stage_set;
   logic [N*PW-1:0] stage_pkt;
   logic            hazard;
   logic            out_valid;
   logic            out_ready;
   logic [SB-1:0]   out_set;
   logic [PW-1:0]   out_pkt;
`ifdef LLC_PIPE_STATS_EN
   logic [31:0]     stat_h;
   logic [31:0]     stat_s;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   llc_pipe_ctrl #(.NUM_STAGES(N), .SET_BITS(SB), .PKT_WIDTH(PW)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .flush_i       (flush),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .in_set_i      (in_set),
      .in_pkt_i      (in_pkt),
      .stage_done_i  (done),
      .stage_valid_o (stage_valid),
      .stage_set_o   (stage_set),
      .stage_pkt_o   (stage_pkt),
      .hazard_o      (hazard),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .out_set_o     (out_set),
      .out_pkt_o     (out_pkt)
`ifdef LLC_PIPE_STATS_EN
      ,
      .stat_hazard_cnt_o (stat_h),
      .stat_stall_cnt_o  (stat_s)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          iv;
      logic [SB-1:0] s;
      logic [PW-1:0] p;
      logic          er;
      logic          eh;
      logic          eo;
      logic [N-1:0]  esv;
      logic [SB-1:0] eset;
      logic [PW-1:0] epkt;
   } vec_t;

   vec_t vecs[$];

   // reference model state: one slot per stage
   logic          m_v [N];
   logic [SB-1:0] m_s [N];
   logic [PW-1:0] m_p [N];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
      end
   endtask

   // Check the combinational outputs mid-cycle, then move past the next edge.
   task automatic look(input string tag, input logic er, input logic eh, input logic eo,
                       input logic [N-1:0] esv, input logic [SB-1:0] eset, input logic [PW-1:0] epkt);
      @(negedge clk);
      chk({tag, " in_ready"},    64'(in_ready),    64'(er));
      chk({tag, " hazard"},      64'(hazard),      64'(eh));
      chk({tag, " out_valid"},   64'(out_valid),   64'(eo));
      chk({tag, " stage_valid"}, 64'(stage_valid), 64'(esv));
      if (eo) begin
         chk({tag, " out_set"}, 64'(out_set), 64'(eset));
         chk({tag, " out_pkt"}, 64'(out_pkt), 64'(epkt));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [SB-1:0] s, input logic [PW-1:0] p);
      in_valid = iv;
      in_set   = s;
      in_pkt   = p;
   endtask

   function automatic vec_t mk(input logic iv, input logic [SB-1:0] s, input logic [PW-1:0] p,
                               input logic er, input logic eh, input logic eo, input logic [N-1:0] esv,
                               input logic [SB-1:0] eset, input logic [PW-1:0] epkt);
      vec_t v;
      v.iv = iv; v.s = s; v.p = p; v.er = er; v.eh = eh; v.eo = eo;
      v.esv = esv; v.eset = eset; v.epkt = epkt;
      return v;
   endfunction

   // Reference: sweep slots from the tail; an entry moves forward whenever it
   // is done and the slot ahead is empty after the downstream moves.
   task automatic model_step(output logic e_rdy, output logic e_hz, output logic e_ov,
                             output logic [N-1:0] e_sv, output logic [SB-1:0] e_oset,
                             output logic [PW-1:0] e_opkt);
      logic          occ [N];
      logic [SB-1:0] ts [N];
      logic [PW-1:0] tp [N];
      e_hz = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (in_valid && m_v[i] && m_s[i] == in_set) e_hz = 1'b1;
         e_sv[i] = m_v[i];
         occ[i]  = m_v[i];
         ts[i]   = m_s[i];
         tp[i]   = m_p[i];
      end
      e_oset = m_s[N-1];
      e_opkt = m_p[N-1];
      if (flush) begin
         e_rdy = 1'b0;
         e_ov  = 1'b0;
         for (int i = 0; i < N; i++) occ[i] = 1'b0;
      end else begin
         e_ov = m_v[N-1] && done[N-1];
         if (e_ov && out_ready) occ[N-1] = 1'b0;
         for (int i = N-2; i >= 0; i--) begin
            if (occ[i] && done[i] && !occ[i+1]) begin
               occ[i+1] = 1'b1;
               ts[i+1]  = ts[i];
               tp[i+1]  = tp[i];
               occ[i]   = 1'b0;
            end
         end
         e_rdy = !occ[0] && !e_hz;
         if (in_valid && e_rdy) begin
            occ[0] = 1'b1;
            ts[0]  = in_set;
            tp[0]  = in_pkt;
         end
      end
      for (int i = 0; i < N; i++) begin
         m_v[i] = occ[i];
         m_s[i] = ts[i];
         m_p[i] = tp[i];
      end
   endtask

   initial begin
      logic          r_rdy, r_hz, r_ov;
      logic [N-1:0]  r_sv;
      logic [SB-1:0] r_set;
      logic [PW-1:0] r_pkt;
`ifdef LLC_PIPE_STATS_EN
      logic [31:0]   base;
`endif

      // ---------------- reset ----------------
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; done = '1;
      drive(1'b1, 9'h003, 16'h0);
      repeat (2) @(negedge clk);
      chk("reset stage_valid", 64'(stage_valid), 64'd0);
      chk("reset in_ready",    64'(in_ready),    64'd0);
      chk("reset out_valid",   64'(out_valid),   64'd0);
      chk("reset hazard",      64'(hazard),      64'd0);
      chk("reset stage_set",   64'(stage_set),   64'd0);
`ifdef LLC_PIPE_STATS_EN
      chk("reset stat_hazard", 64'(stat_h), 64'd0);
      chk("reset stat_stall",  64'(stat_s), 64'd0);
`endif
      drive(1'b0, '0, '0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ---------------- vector table: latency and streaming ----------------
      vecs.push_back(mk(1, 9'h010, 16'hA5A5, 1, 0, 0, 5'b00000, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5'b00001, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5'b00010, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5'b00100, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5'b01000, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 5'b10000, 9'h010, 16'hA5A5));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5'b00000, 0, 0));
      vecs.push_back(mk(1, 9'h001, 16'h1001, 1, 0, 0, 5'b00000, 0, 0));
      vecs.push_back(mk(1, 9'h002, 16'h1002, 1, 0, 0, 5'b00001, 0, 0));
      vecs.push_back(mk(1, 9'h003, 16'h1003, 1, 0, 0, 5'b00011, 0, 0));
      vecs.push_back(mk(1, 9'h004, 16'h1004, 1, 0, 0, 5'b00111, 0, 0));
      vecs.push_back(mk(1, 9'h005, 16'h1005, 1, 0, 0, 5'b01111, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 5'b11111, 9'h001, 16'h1001));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 5'b11110, 9'h002, 16'h1002));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 5'b11100, 9'h003, 16'h1003));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 5'b11000, 9'h004, 16'h1004));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 5'b10000, 9'h005, 16'h1005));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5'b00000, 0, 0));
      foreach (vecs[i]) begin
         drive(vecs[i].iv, vecs[i].s, vecs[i].p);
         $display("vec %0d: in_valid=%0d set=%03h pkt=%04h", i, vecs[i].iv, vecs[i].s, vecs[i].p);
         look($sformatf("vec%0d", i), vecs[i].er, vecs[i].eh, vecs[i].eo,
              vecs[i].esv, vecs[i].eset, vecs[i].epkt);
      end

      // ---------------- same-set hazard ----------------
`ifdef LLC_PIPE_STATS_EN
      base = stat_h;
`endif
      drive(1'b1, 9'h07F, 16'h0001);
      look("haz first", 1, 0, 0, 5'b00000, 0, 0);
      in_pkt = 16'h0002;
      for (int k = 0; k <= 12; k++) begin
         logic [N-1:0] sv;
         logic [PW-1:0] ep;
         if (k <= 4)       sv = 5'(1 << k);
         else if (k <= 5)  sv = '0;
         else if (k <= 10) sv = 5'(1 << (k - 6));
         else              sv = '0;
         ep = (k == 4) ? 16'h0001 : 16'h0002;
         $display("haz cycle %0d", k);
         look($sformatf("haz k%0d", k), (k >= 5), (k <= 4), (k == 4 || k == 10), sv, 9'h07F, ep);
         if (k == 5) in_valid = 1'b0;
      end
`ifdef LLC_PIPE_STATS_EN
      chk("haz stat_hazard delta", 64'(stat_h - base), 64'd5);
`endif

      // ---------------- backpressure ----------------
      out_ready = 1'b0;
      for (int r = 0; r < 5; r++) begin
         drive(1'b1, 9'(9'h100 + r), 16'(16'h2000 + r));
         $display("bp push set=%03h", in_set);
         look($sformatf("bp fill%0d", r), 1, 0, 0, 5'((1 << r) - 1), 0, 0);
      end
`ifdef LLC_PIPE_STATS_EN
      base = stat_s;
`endif
      drive(1'b1, 9'h1FF, 16'h0000);
      for (int r = 0; r < 3; r++) begin
         $display("bp hold %0d", r);
         look($sformatf("bp hold%0d", r), 0, 0, 1, 5'b11111, 9'h100, 16'h2000);
      end
      drive(1'b0, '0, '0);
      out_ready = 1'b1;
`ifdef LLC_PIPE_STATS_EN
      chk("bp stat_stall delta", 64'(stat_s - base), 64'd3);
`endif
      for (int r = 0; r < 5; r++) begin
         $display("bp drain %0d", r);
         look($sformatf("bp drain%0d", r), 1, 0, 1, 5'(5'b11111 << r), 9'(9'h100 + r), 16'(16'h2000 + r));
      end
      look("bp empty", 1, 0, 0, 5'b00000, 0, 0);

      // ---------------- mid-pipe stall ----------------
      for (int r = 0; r < 3; r++) begin
         drive(1'b1, 9'(9'h030 + r), 16'(16'h3000 + r));
         $display("stall push set=%03h", in_set);
         look($sformatf("st push%0d", r), 1, 0, 0, 5'((1 << r) - 1), 0, 0);
      end
      drive(1'b0, '0, '0);
      look("st run0", 1, 0, 0, 5'b00111, 0, 0);
      look("st run1", 1, 0, 0, 5'b01110, 0, 0);
      done = 5'b11011;
      look("st frz0", 1, 0, 1, 5'b11100, 9'h030, 16'h3000);
      look("st frz1", 1, 0, 1, 5'b10100, 9'h031, 16'h3001);
      chk("st frozen set", 64'(stage_set[2*SB +: SB]), 64'h032);
      look("st frz2", 1, 0, 0, 5'b00100, 0, 0);
      look("st frz3", 1, 0, 0, 5'b00100, 0, 0);
      done = '1;
      look("st go0", 1, 0, 0, 5'b00100, 0, 0);
      look("st go1", 1, 0, 0, 5'b01000, 0, 0);
      look("st go2", 1, 0, 1, 5'b10000, 9'h032, 16'h3002);
      look("st go3", 1, 0, 0, 5'b00000, 0, 0);

      // ---------------- flush ----------------
      for (int r = 0; r < 3; r++) begin
         drive(1'b1, 9'(9'h040 + r), 16'(16'h4000 + r));
         $display("flush push set=%03h", in_set);
         look($sformatf("fl push%0d", r), 1, 0, 0, 5'((1 << r) - 1), 0, 0);
      end
      drive(1'b0, '0, '0);
      look("fl run0", 1, 0, 0, 5'b00111, 0, 0);
      look("fl run1", 1, 0, 0, 5'b01110, 0, 0);
      flush = 1'b1;
      drive(1'b1, 9'h050, 16'h5555);
      look("fl flush", 0, 0, 0, 5'b11100, 0, 0);
      flush = 1'b0;
      drive(1'b0, '0, '0);
      look("fl after0", 1, 0, 0, 5'b00000, 0, 0);
      look("fl after1", 1, 0, 0, 5'b00000, 0, 0);

      // ---------------- reset mid-traffic ----------------
      for (int r = 0; r < 3; r++) begin
         drive(1'b1, 9'(9'h060 + r), 16'(16'h6000 + r));
         $display("rst push set=%03h", in_set);
         look($sformatf("rs push%0d", r), 1, 0, 0, 5'((1 << r) - 1), 0, 0);
      end
      drive(1'b1, 9'h060, 16'h6666);
      #1;
      chk("rs pre hazard", 64'(hazard), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rs stage_valid", 64'(stage_valid), 64'd0);
      chk("rs in_ready",    64'(in_ready),    64'd0);
      chk("rs out_valid",   64'(out_valid),   64'd0);
      chk("rs hazard",      64'(hazard),      64'd0);
      chk("rs stage_set",   64'(stage_set),   64'd0);
      chk("rs out_pkt",     64'(out_pkt),     64'd0);
      drive(1'b0, '0, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      look("rs recovered", 1, 0, 0, 5'b00000, 0, 0);

      // ---------------- random traffic vs reference ----------------
      for (int i = 0; i < N; i++) begin
         m_v[i] = 1'b0;
         m_s[i] = '0;
         m_p[i] = '0;
      end
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_set    = 9'($urandom_range(0, 7));
         in_pkt    = 16'($urandom);
         for (int i = 0; i < N; i++) done[i] = ($urandom_range(0, 9) < 8);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         @(negedge clk);
         model_step(r_rdy, r_hz, r_ov, r_sv, r_set, r_pkt);
         chk($sformatf("rnd%0d in_ready", c),    64'(in_ready),    64'(r_rdy));
         chk($sformatf("rnd%0d hazard", c),      64'(hazard),      64'(r_hz));
         chk($sformatf("rnd%0d out_valid", c),   64'(out_valid),   64'(r_ov));
         chk($sformatf("rnd%0d stage_valid", c), 64'(stage_valid), 64'(r_sv));
         if (r_ov) begin
            chk($sformatf("rnd%0d out_set", c), 64'(out_set), 64'(r_set));
            chk($sformatf("rnd%0d out_pkt", c), 64'(out_pkt), 64'(r_pkt));
            if (out_ready) $display("rnd %0d retire set=%03h pkt=%04h", c, r_set, r_pkt);
         end
         @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
